id_stage_pipe: RTL and testbench

//  Parametrised instruction-decode stage: register file, sign-extend, branch-target adder, main decode,

---
 rtl/id_stage_pipe.sv | 176 +++++++++++++++++
 tb/tb_id_stage_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
// Instruction-decode stage sitting between IF/ID and EX: register file,
// immediate sign-extension, branch-target adder, main decoder, load-use
// hazard detection and the ID/EX pipeline register with valid/hold/flush.
//
// Optional feature: define RF_BYPASS_EN to make register-file reads of the
// register currently being written return the write data (write-through).
// Without it, such a read returns the pre-write value.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid, i_instr      instruction from IF/ID and its valid flag
//   i_next_pc             PC+4 of the instruction
//   i_reg_write/_reg/_data  write-back port into the register file
//   i_flush               squash the instruction entering ID/EX
//   i_ex_hold             downstream stall, ID/EX keeps its contents
//   o_stall               load-use stall request towards IF
//   o_valid ... o_EX_control  ID/EX register contents
// ---------------------------------------------------------------------------
module id_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int NREG     = 32,
    parameter int IMM_W    = 16,
    parameter int BR_SHIFT = 2,
    localparam int REG_AW  = $clog2(NREG)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [31:0]       i_instr,
    input  logic [DATA_W-1:0] i_next_pc,
    input  logic              i_reg_write,
    input  logic [REG_AW-1:0] i_write_reg,
    input  logic [DATA_W-1:0] i_write_data,
    input  logic              i_flush,
    input  logic              i_ex_hold,
    output logic              o_stall,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_branch_pc,
    output logic [DATA_W-1:0] o_read_data1,
    output logic [DATA_W-1:0] o_read_data2,
    output logic [DATA_W-1:0] o_imm,
    output logic [REG_AW-1:0] o_sou_reg,
    output logic [REG_AW-1:0] o_tar_reg,
    output logic [REG_AW-1:0] o_des_reg,
    output logic [1:0]        o_WB_control,
    output logic [2:0]        o_MEM_control,
    output logic [3:0]        o_EX_control
);

    // ---------------- instruction fields ----------------
    logic [5:0]        w_op;
    logic [REG_AW-1:0] w_rs, w_rt, w_rd;
    logic [IMM_W-1:0]  w_imm_raw;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_branch_pc;

    assign w_op      = i_instr[31:26];
    assign w_rs      = i_instr[21 +: REG_AW];
    assign w_rt      = i_instr[16 +: REG_AW];
    assign w_rd      = i_instr[11 +: REG_AW];
    assign w_imm_raw = i_instr[IMM_W-1:0];
    assign w_imm_ext = {{(DATA_W-IMM_W){w_imm_raw[IMM_W-1]}}, w_imm_raw};
    assign w_branch_pc = i_next_pc + (w_imm_ext << BR_SHIFT);

    // ---------------- register file ----------------
    // One flop word per register; entry 0 never has its write enable asserted
    // so it stays at zero and synthesis trims it.
    logic [DATA_W-1:0] r_rf [NREG];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_rf[gi] <= '0;
                end else if (i_reg_write && (gi != 0) && (i_write_reg == REG_AW'(gi))) begin
                    r_rf[gi] <= i_write_data;
                end
            end
        end
    endgenerate

    logic [DATA_W-1:0] w_rd_data1, w_rd_data2;

`ifdef RF_BYPASS_EN
    logic w_byp1, w_byp2;
    assign w_byp1 = i_reg_write && (i_write_reg != '0) && (i_write_reg == w_rs);
    assign w_byp2 = i_reg_write && (i_write_reg != '0) && (i_write_reg == w_rt);
    assign w_rd_data1 = w_byp1 ? i_write_data : r_rf[w_rs];
    assign w_rd_data2 = w_byp2 ? i_write_data : r_rf[w_rt];
`else
    assign w_rd_data1 = r_rf[w_rs];
    assign w_rd_data2 = r_rf[w_rt];
`endif

    // ---------------- main decoder ----------------
    logic [1:0] w_wb_ctl;
    logic [2:0] w_mem_ctl;
    logic [3:0] w_ex_ctl;

    always_comb begin
        w_wb_ctl  = 2'b00;
        w_mem_ctl = 3'b000;
        w_ex_ctl  = 4'b0000;
        case (w_op)
            6'b000000: begin w_wb_ctl = 2'b01; w_mem_ctl = 3'b000; w_ex_ctl = 4'b0101; end
            6'b100011: begin w_wb_ctl = 2'b11; w_mem_ctl = 3'b010; w_ex_ctl = 4'b1000; end
            6'b101011: begin w_wb_ctl = 2'b00; w_mem_ctl = 3'b100; w_ex_ctl = 4'b1000; end
            6'b000100: begin w_wb_ctl = 2'b00; w_mem_ctl = 3'b001; w_ex_ctl = 4'b0010; end
            6'b001000: begin w_wb_ctl = 2'b01; w_mem_ctl = 3'b000; w_ex_ctl = 4'b1000; end
            default:   begin w_wb_ctl = 2'b00; w_mem_ctl = 3'b000; w_ex_ctl = 4'b0000; end
        endcase
    end

    // ---------------- ID/EX register ----------------
    logic              r_valid;
    logic [DATA_W-1:0] r_branch_pc, r_read_data1, r_read_data2, r_imm;
    logic [REG_AW-1:0] r_sou_reg, r_tar_reg, r_des_reg;
    logic [1:0]        r_wb_ctl;
    logic [2:0]        r_mem_ctl;
    logic [3:0]        r_ex_ctl;

    // Load-use: the load in EX (MemRead) targets a register this instruction
    // reads. rt is compared regardless of op, which is conservative.
    logic w_stall;
    assign w_stall = i_valid && r_valid && r_mem_ctl[1] && (r_tar_reg != '0) &&
                     ((r_tar_reg == w_rs) || (r_tar_reg == w_rt));

    // Controls are only propagated for a real, unsquashed, unstalled instruction.
    logic w_ctl_en;
    assign w_ctl_en = i_valid && !i_flush && !w_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid      <= 1'b0;
            r_branch_pc  <= '0;
            r_read_data1 <= '0;
            r_read_data2 <= '0;
            r_imm        <= '0;
            r_sou_reg    <= '0;
            r_tar_reg    <= '0;
            r_des_reg    <= '0;
            r_wb_ctl     <= '0;
            r_mem_ctl    <= '0;
            r_ex_ctl     <= '0;
        end else if (i_flush || !i_ex_hold) begin
            // Flush beats hold; data fields load in every non-hold case.
            r_valid      <= w_ctl_en;
            r_branch_pc  <= w_branch_pc;
            r_read_data1 <= w_rd_data1;
            r_read_data2 <= w_rd_data2;
            r_imm        <= w_imm_ext;
            r_sou_reg    <= w_rs;
            r_tar_reg    <= w_rt;
            r_des_reg    <= w_rd;
            r_wb_ctl     <= w_ctl_en ? w_wb_ctl  : 2'b00;
            r_mem_ctl    <= w_ctl_en ? w_mem_ctl : 3'b000;
            r_ex_ctl     <= w_ctl_en ? w_ex_ctl  : 4'b0000;
        end
    end

    assign o_stall       = w_stall;
    assign o_valid       = r_valid;
    assign o_branch_pc   = r_branch_pc;
    assign o_read_data1  = r_read_data1;
    assign o_read_data2  = r_read_data2;
    assign o_imm         = r_imm;
    assign o_sou_reg     = r_sou_reg;
    assign o_tar_reg     = r_tar_reg;
    assign o_des_reg     = r_des_reg;
    assign o_WB_control  = r_wb_ctl;
    assign o_MEM_control = r_mem_ctl;
    assign o_EX_control  = r_ex_ctl;

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [31:0] i_instr;
    logic [31:0] i_next_pc;
    logic        i_reg_write;
    logic [4:0]  i_write_reg;
    logic [31:0] i_write_data;
    logic        i_flush;
    logic        i_ex_hold;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_branch_pc;
    logic [31:0] o_read_data1;
    logic [31:0] o_read_data2;
    logic [31:0] o_imm;
    logic [4:0]  o_sou_reg;
    logic [4:0]  o_tar_reg;
    logic [4:0]  o_des_reg;
    logic [1:0]  o_WB_control;
    logic [2:0]  o_MEM_control;
    logic [3:0]  o_EX_control;

    int vectors     = 0;
    int miscompares = 0;

    id_stage_pipe dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_instr(i_instr),
        .i_next_pc(i_next_pc), .i_reg_write(i_reg_write), .i_write_reg(i_write_reg),
        .i_write_data(i_write_data), .i_flush(i_flush), .i_ex_hold(i_ex_hold),
        .o_stall(o_stall), .o_valid(o_valid), .o_branch_pc(o_branch_pc),
        .o_read_data1(o_read_data1), .o_read_data2(o_read_data2), .o_imm(o_imm),
        .o_sou_reg(o_sou_reg), .o_tar_reg(o_tar_reg), .o_des_reg(o_des_reg),
        .o_WB_control(o_WB_control), .o_MEM_control(o_MEM_control),
        .o_EX_control(o_EX_control)
    );

    always #5 i_clk = ~i_clk;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_BAD = 6'b111111;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] mkr(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
        return {OP_R, rs, rt, rd, 11'h000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
    endtask

    // Advance one clock; sample 1 time unit after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    logic [31:0] exp_bypass;

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_instr = '0; i_next_pc = '0;
        i_reg_write = 1'b0; i_write_reg = '0; i_write_data = '0;
        i_flush = 1'b0; i_ex_hold = 1'b0;
        #12;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_rd1",   o_read_data1, 32'd0);
        chk("rst_ex",    {28'd0, o_EX_control}, 32'd0);
        i_rst_n = 1'b1;

        // write r3=AA; concurrently decode add rd=1 rs=5 rt=0 (r5 reads 0)
        i_reg_write = 1'b1; i_write_reg = 5'd3; i_write_data = 32'h0000_00AA;
        i_valid = 1'b1; i_instr = mkr(5'd5, 5'd0, 5'd1);
        step();
        chk("r5_zero",   o_read_data1, 32'd0);
        chk("add1_vld",  {31'd0, o_valid}, 32'd1);
        chk("add1_wb",   {30'd0, o_WB_control}, 32'h1);
        chk("add1_des",  {27'd0, o_des_reg}, 32'd1);

        // add rd=4 rs=3 rt=3
        i_reg_write = 1'b0;
        i_instr = mkr(5'd3, 5'd3, 5'd4);
        step();
        chk("add2_rd1",  o_read_data1, 32'hAA);
        chk("add2_rd2",  o_read_data2, 32'hAA);
        chk("add2_ex",   {28'd0, o_EX_control}, 32'h5);
        chk("add2_vld",  {31'd0, o_valid}, 32'd1);

        // lw r2, 0(r3) followed by add using r2 -> one stall + bubble
        i_instr = mk(OP_LW, 5'd3, 5'd2, 16'h0000);
        step();
        chk("lw_wb",     {30'd0, o_WB_control}, 32'h3);
        chk("lw_mem",    {29'd0, o_MEM_control}, 32'h2);
        chk("lw_ex",     {28'd0, o_EX_control}, 32'h8);
        i_instr = mkr(5'd2, 5'd0, 5'd5);
        #1;
        chk("lu_stall",  {31'd0, o_stall}, 32'd1);
        step();
        chk("bub_vld",   {31'd0, o_valid}, 32'd0);
        chk("bub_mem",   {29'd0, o_MEM_control}, 32'd0);
        chk("bub_ex",    {28'd0, o_EX_control}, 32'd0);
        chk("bub_wb",    {30'd0, o_WB_control}, 32'd0);
        chk("bub_stall", {31'd0, o_stall}, 32'd0);
        step();
        chk("lu_add_vld", {31'd0, o_valid}, 32'd1);
        chk("lu_add_ex",  {28'd0, o_EX_control}, 32'h5);
        chk("lu_add_rs",  {27'd0, o_sou_reg}, 32'd2);

        // beq branch targets
        i_next_pc = 32'h100;
        i_instr = mk(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
        step();
        chk("beq_neg_pc",  o_branch_pc, 32'h0FC);
        chk("beq_neg_imm", o_imm, 32'hFFFF_FFFF);
        chk("beq_mem",     {29'd0, o_MEM_control}, 32'h1);
        chk("beq_ex",      {28'd0, o_EX_control}, 32'h2);
        i_instr = mk(OP_BEQ, 5'd0, 5'd0, 16'h0004);
        step();
        chk("beq_pos_pc",  o_branch_pc, 32'h110);
        chk("beq_pos_imm", o_imm, 32'h4);

        // flush + hold on a valid sw: flush wins
        i_instr = mk(OP_SW, 5'd3, 5'd3, 16'h0008);
        i_flush = 1'b1; i_ex_hold = 1'b1;
        step();
        chk("fh_vld", {31'd0, o_valid}, 32'd0);
        chk("fh_mem", {29'd0, o_MEM_control}, 32'd0);
        i_flush = 1'b0; i_ex_hold = 1'b0;
        step();
        chk("sw_mem", {29'd0, o_MEM_control}, 32'h4);
        chk("sw_vld", {31'd0, o_valid}, 32'd1);
        // hold for three cycles while a different instruction waits
        i_ex_hold = 1'b1;
        i_instr = mk(OP_ADDI, 5'd3, 5'd6, 16'h0055);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_mem", {29'd0, o_MEM_control}, 32'h4);
            chk("hold_imm", o_imm, 32'h8);
            chk("hold_tar", {27'd0, o_tar_reg}, 32'd3);
        end
        i_ex_hold = 1'b0;
        step();
        chk("addi_imm", o_imm, 32'h55);
        chk("addi_wb",  {30'd0, o_WB_control}, 32'h1);
        chk("addi_ex",  {28'd0, o_EX_control}, 32'h8);
        chk("addi_tar", {27'd0, o_tar_reg}, 32'd6);

        // invalid slot and unknown opcode
        i_valid = 1'b0;
        step();
        chk("inv_vld", {31'd0, o_valid}, 32'd0);
        chk("inv_wb",  {30'd0, o_WB_control}, 32'd0);
        i_valid = 1'b1; i_instr = mk(OP_BAD, 5'd1, 5'd1, 16'h1234);
        step();
        chk("bad_vld", {31'd0, o_valid}, 32'd1);
        chk("bad_ctl", {23'd0, o_WB_control, o_MEM_control, o_EX_control}, 32'd0);

        // write r7 and read it in the same cycle
`ifdef RF_BYPASS_EN
        exp_bypass = 32'h1234;
`else
        exp_bypass = 32'h0;
`endif
        i_reg_write = 1'b1; i_write_reg = 5'd7; i_write_data = 32'h1234;
        i_instr = mkr(5'd7, 5'd0, 5'd8);
        step();
        chk("r7_same", o_read_data1, exp_bypass);
        i_reg_write = 1'b0;
        step();
        chk("r7_after", o_read_data1, 32'h1234);
        // write to r0 is never observed
        i_reg_write = 1'b1; i_write_reg = 5'd0; i_write_data = 32'hDEAD_BEEF;
        i_instr = mkr(5'd0, 5'd0, 5'd8);
        step();
        chk("r0_same", o_read_data1, 32'd0);
        i_reg_write = 1'b0;
        step();
        chk("r0_after", o_read_data2, 32'd0);

        // asynchronous reset mid-cycle
        i_instr = mkr(5'd3, 5'd7, 5'd9);
        step();
        chk("pre_rst_vld", {31'd0, o_valid}, 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_vld", {31'd0, o_valid}, 32'd0);
        chk("arst_rd1", o_read_data1, 32'd0);
        chk("arst_ex",  {28'd0, o_EX_control}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        chk("post_rst_vld", {31'd0, o_valid}, 32'd1);
        chk("post_rst_r3",  o_read_data1, 32'd0);
        chk("post_rst_r7",  o_read_data2, 32'd0);
        chk("post_rst_ex",  {28'd0, o_EX_control}, 32'h5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
